// File: rtl/kamus_muldiv_ctrl.sv
// RV32M multi-cycle multiply/divide sequencer beside the execute stage.
// Optional single-cycle multiplier: define KAMUS_MULDIV_FAST_MUL_EN.
module kamus_muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o
);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_e;

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [4:0]          rd_q, rd_d;
    logic                neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                done_q, done_d, busy_q, busy_d;

    logic                accept, signed_a_in, signed_b_in, neg_a_in, neg_b_in;
    logic                div_zero, div_ovf, special_in, fast_mul_in;
    logic [XLEN-1:0]     special_res, fast_res, sign_res;
    logic [XLEN:0]       mul_sum, rem_sh;
    logic [XLEN+1:0]     div_diff;
    logic                prod_neg;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo, rem;

    assign accept      = (state_q == IDLE) && start_i && !flush_i;
    assign signed_a_in = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
    assign signed_b_in = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    assign neg_a_in    = signed_a_in && rs1_i[XLEN-1];
    assign neg_b_in    = signed_b_in && rs2_i[XLEN-1];

    // Divide corner cases bypass the iteration and load the result at accept.
    assign div_zero    = op_i[2] && (rs2_i == {XLEN{1'b0}});
    assign div_ovf     = op_i[2] && !op_i[0] && (rs1_i == {1'b1, {(XLEN-1){1'b0}}})
                         && (rs2_i == {XLEN{1'b1}});
    assign special_in  = div_zero || div_ovf;
    assign special_res = div_zero ? (op_i[1] ? rs1_i : {XLEN{1'b1}})
                                  : (op_i[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}});

`ifdef KAMUS_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
    assign fast_a      = {{XLEN{neg_a_in}}, rs1_i};
    assign fast_b      = {{XLEN{neg_b_in}}, rs2_i};
    assign fast_prod   = fast_a * fast_b;
    assign fast_mul_in = !op_i[2];
    assign fast_res    = (op_i == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
    assign fast_mul_in = 1'b0;
    assign fast_res    = {XLEN{1'b0}};
`endif

    // Shift-add multiply retires one multiplier bit (b_q[0]) per cycle from the top half.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (b_q[0] ? a_q : {XLEN{1'b0}})};
    assign rem_sh   = {acc_q[2*XLEN-1:XLEN], a_q[XLEN-1]};
    assign div_diff = {1'b0, rem_sh} - {2'b00, b_q};

    assign prod_neg = neg_a_q ^ neg_b_q;
    assign prod     = prod_neg ? ({(2*XLEN){1'b0}} - acc_q) : acc_q;
    assign quo      = prod_neg ? ({XLEN{1'b0}} - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    assign rem      = neg_a_q ? ({XLEN{1'b0}} - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        case (op_q)
            OP_MUL:                        sign_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  sign_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               sign_res = quo;
            default:                       sign_res = rem;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            op_q     <= 3'd0;
            rd_q     <= 5'd0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= 5'd0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_i) state_d = (special_in || fast_mul_in) ? DONE : CALC;
                CALC:    if (cnt_q == 5'd31) state_d = SIGN;
                SIGN:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        op_d     = op_q;
        rd_d     = rd_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = op_i;
                    rd_d    = rd_addr_i;
                    neg_a_d = neg_a_in;
                    neg_b_d = neg_b_in;
                    a_d     = neg_a_in ? ({XLEN{1'b0}} - rs1_i) : rs1_i;
                    b_d     = neg_b_in ? ({XLEN{1'b0}} - rs2_i) : rs2_i;
                    acc_d   = '0;
                    cnt_d   = 5'd0;
                    if (special_in)       result_d = special_res;
                    else if (fast_mul_in) result_d = fast_res;
                end
            end
            CALC: begin
                cnt_d = cnt_q + 5'd1;
                if (op_q[2]) begin
                    // Restoring divide: dividend bits stream out of a_q's MSB, quotient fills acc low half.
                    a_d = {a_q[XLEN-2:0], 1'b0};
                    if (!div_diff[XLEN+1])
                        acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    else
                        acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                end else begin
                    b_d   = {1'b0, b_q[XLEN-1:1]};
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end
            end
            SIGN: begin
                if (!flush_i) result_d = sign_res;
            end
            default: ;
        endcase
    end

    always_comb begin
        done_d  = (state_d == DONE);
        busy_d  = (state_d == CALC) || (state_d == SIGN);
        stall_o = accept || (state_q == CALC) || (state_q == SIGN);
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign result_o  = result_q;
    assign rd_addr_o = rd_q;

endmodule

// File: tb/tb_kamus_muldiv_ctrl.sv
// Self-checking bench for kamus_muldiv_ctrl: directed vectors, flush/reset sequences,
// and random operations against an arithmetic reference model.
module tb_kamus_muldiv_ctrl;

`ifdef KAMUS_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int ITER_LAT = 34;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op_in;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;

    int n_cmp  = 0;
    int n_fail = 0;

    kamus_muldiv_ctrl #(.XLEN(32)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .op_i      (op_in),
        .rs1_i     (rs1),
        .rs2_i     (rs2),
        .rd_addr_i (rd_in),
        .flush_i   (flush),
        .stall_o   (stall_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o),
        .rd_addr_o (rd_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    // Reference: plain 64-bit arithmetic following the RV32M definitions.
    function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                                 input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub;
                return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    function automatic int model_latency(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        if (op < 3'd4) return MUL_LAT;
        if (b == 32'd0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return ITER_LAT;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the DONE cycle.
    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd,
                                 input logic [31:0] exp_res, input int exp_lat);
        int  k;
        int  stall_drop;
        bit  seen;
        op_in = op;
        rs1   = a;
        rs2   = b;
        rd_in = rd;
        start = 1'b1;
        #1;
        checkOutput({tag, " stall_at_accept"}, {31'd0, stall_o}, 32'd1);
        seen       = 1'b0;
        k          = 0;
        stall_drop = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            rs1 = $urandom;
            rs2 = $urandom;
            if (k == 1)
                checkOutput({tag, " busy_first_cycle"}, {31'd0, busy_o},
                            (exp_lat > 1) ? 32'd1 : 32'd0);
            if (done_o) seen = 1'b1;
            else if (!stall_o) stall_drop++;
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL %s timeout: got no done_o in 40 cycles, expected done at T+%0d",
                     tag, exp_lat);
        end else begin
            checkOutput({tag, " latency"}, 32'(k), 32'(exp_lat));
            checkOutput({tag, " result"}, result_o, exp_res);
            checkOutput({tag, " rd_addr"}, {27'd0, rd_addr_o}, {27'd0, rd});
            checkOutput({tag, " stall_in_done"}, {31'd0, stall_o}, 32'd0);
            checkOutput({tag, " stall_gaps"}, 32'(stall_drop), 32'd0);
        end
        start = 1'b0;
        @(negedge clk);
        checkOutput({tag, " done_pulse_end"}, {31'd0, done_o}, 32'd0);
        checkOutput({tag, " busy_after"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion before 1 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          done_seen;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        logic [4:0]  rrd;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT};
        vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_LAT};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, ITER_LAT};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, ITER_LAT};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        ITER_LAT};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         ITER_LAT};
        vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};

        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op_in = 3'd0;
        rs1   = 32'd0;
        rs2   = 32'd0;
        rd_in = 5'd0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset busy", {31'd0, busy_o}, 32'd0);
        checkOutput("reset done", {31'd0, done_o}, 32'd0);
        checkOutput("reset result", result_o, 32'd0);
        checkOutput("reset rd_addr", {27'd0, rd_addr_o}, 32'd0);
        checkOutput("reset stall_idle", {31'd0, stall_o}, 32'd0);
        start = 1'b1;
        #1;
        checkOutput("reset stall_with_start", {31'd0, stall_o}, 32'd1);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                          5'(i + 1), vecs[i].exp, vecs[i].lat);
        end

        // Flush a DIV mid-iteration, then start a fresh one in the first IDLE cycle.
        op_in     = 3'd4;
        rs1       = 32'hFFFF_FFF9;
        rs2       = 32'd2;
        rd_in     = 5'd20;
        start     = 1'b1;
        done_seen = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done_o) done_seen = 1'b1;
        end
        flush = 1'b1;
        start = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        if (done_o) done_seen = 1'b1;
        checkOutput("flush busy", {31'd0, busy_o}, 32'd0);
        checkOutput("flush stall", {31'd0, stall_o}, 32'd0);
        checkOutput("flush no_done", {31'd0, done_seen}, 32'd0);
        applyStimulus("after_flush", 3'd5, 32'd100, 32'd7, 5'd21, 32'd14, ITER_LAT);

        // Asynchronous reset in the middle of a MUL.
        op_in = 3'd0;
        rs1   = 32'd7;
        rs2   = 32'hFFFF_FFFD;
        rd_in = 5'd9;
        start = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("pre_reset busy", {31'd0, busy_o}, (MUL_LAT > 5) ? 32'd1 : 32'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset busy", {31'd0, busy_o}, 32'd0);
        checkOutput("async_reset done", {31'd0, done_o}, 32'd0);
        checkOutput("async_reset result", result_o, 32'd0);
        checkOutput("async_reset rd_addr", {27'd0, rd_addr_o}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus("after_reset", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd10, 32'hFFFF_FFEB, MUL_LAT);

        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       ra = 32'd0;
                1:       ra = 32'h8000_0000;
                2:       ra = 32'hFFFF_FFFF;
                3:       ra = 32'($urandom_range(0, 50));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1:       rb = 32'h8000_0000;
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = 32'($urandom_range(1, 50));
                default: rb = $urandom;
            endcase
            rrd = 5'($urandom);
            applyStimulus($sformatf("rand%0d op%0d %h %h", i, rop, ra, rb), rop, ra, rb, rrd,
                          model_result(rop, ra, rb), model_latency(rop, ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
